keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Upstream stage of the dot-matrix display. Scans the 3x3 tic-tac-toe keypad and debounces presses.
//  Rejects presses on occupied cells or after game over. Emits the accepted cell as the one-hot
//  location code kCode={col_oh,row_oh} consumed by the display, and owns the move/turn bookkeeping.
// PARAMETERS
//  SCAN_DIV      500000  clk cycles per scan tick (10 ms at 50 MHz); sim uses 4
//  DEBOUNCE_CNT  3       consecutive identical tick samples required for press and for release
// PORTS
//  clk        in   1  system clock
//  reset_n    in   1  asynchronous, active-low reset
//  col        in   3  keypad column sense, active-low, pulled up (3'b111 = nothing)
//  new_game   in   1  sync pulse: clear board, turn, kCode
//  game_over  in   1  level from win controller (winner!=0); blocks acceptance
//  row        out  3  keypad row drive, active-low, exactly one bit low
//  kCode      out  6  last accepted cell: [5:3] col one-hot (c0=001,c1=010,c2=100),
//                     [2:0] row one-hot (r0=100,r1=010,r2=001); e.g. r0c0=6'b001100
//  key_valid  out  1  1-clk pulse when kCode updated
//  rejected   out  1  1-clk pulse when debounced press refused
//  turn       out  1  player to move; toggles on each accepted key
//  occupied   out  9  cell mask, bit = row*3+col
// BEHAVIOUR
//  Reset (async, reset_n=0): state=SCAN, row=3'b110 (row0), kCode=0, key_valid=0, rejected=0,
//   turn=0, occupied=0, tick counter=0, debounce count=0, synchronizer flops=3'b111.
//  col passes a 2-flop synchronizer; all decisions use the synced value colS.
//  Tick: counter 0..SCAN_DIV-1, tick=1 for one clk at SCAN_DIV-1, then wraps to 0. Runs in every state.
//  FSM (transitions and samples only on tick unless noted):
//   SCAN:   colS==111 or >1 bit low -> advance row 0->1->2->0 (row 110->101->011->110).
//           Exactly one bit low -> latch row idx/col pattern, cnt=1, go DEBOUNCE (row held).
//   DEBOUNCE: colS==latched -> cnt+1; cnt reaching DEBOUNCE_CNT -> ACCEPT.
//           Mismatch -> cnt=0, advance row, SCAN.
//   ACCEPT: single clk, no tick needed. idx=row*3+col.
//           If new_game: nothing; go RELEASE.
//           Else if game_over | occupied[idx]: rejected=1.
//           Else key_valid=1, kCode<=code, occupied[idx]<=1, turn<=~turn.
//           Go RELEASE, cnt=0.
//   RELEASE: row held. colS==111 -> cnt+1; reaching DEBOUNCE_CNT -> cnt=0, advance row, SCAN.
//           Any bit low -> cnt=0.
//  Latency: key_valid asserts exactly 1 clk after the tick on which cnt reaches DEBOUNCE_CNT.
//  key_valid and rejected are never high together and never high in consecutive clks.
//  new_game (any state, 1 clk): occupied=0, turn=0, kCode=0 next clk. Scan FSM is not reset.
//   It overrides an accept in the same clk.
//  game_over high: presses still scanned and debounced but always rejected; turn and occupied frozen.
//  Full board (occupied=9'h1FF): every press -> rejected.
//  Holding a key yields one event only; re-press needs a debounced release first.
//  Reset mid-DEBOUNCE/RELEASE: returns to SCAN row0; no pulse emitted.
// STRUCTURE
//  Shared package game_defs: FSM state encodings (SCAN, DEBOUNCE, ACCEPT, RELEASE).
//   Also: row/col one-hot kCode constants, cell index width, ROW_IDLE=3'b111.
//   The display and win controller decode kCode and the occupancy mask from these constants.
//  Sub-module scan_divider (SCAN_DIV): free-running tick generator, clk/reset_n in, tick out.
//  Top holds synchronizer, FSM, debounce counter, board/turn registers.
// TESTING (SCAN_DIV=4, DEBOUNCE_CNT=2)
//  Reset: reset_n=0 mid-run -> row=110, kCode=0, turn=0, occupied=0 immediately, no pulses.
//  Press r0c0: col=110 while row=110, held >=3 ticks -> one key_valid, kCode=6'b001100,
//   occupied=9'h001, turn=1.
//  Bounce: col low for 1 tick then 111 -> no key_valid, no rejected, row resumes advancing.
//  Re-press r0c0 after release -> rejected=1, kCode/turn/occupied unchanged.
//  Hold r2c2 (col=011 while row=011) 20 ticks -> exactly one key_valid, kCode=6'b100001,
//   occupied bit8 set.
//  game_over=1, press r1c1 -> rejected.
//  new_game asserted in ACCEPT clk of r1c2 -> no key_valid; occupied=0, turn=0, kCode=0.

Source files
------------

// File: rtl/game_defs.sv
// Shared definitions for the tic-tac-toe keypad, display and win controller:
// scan FSM encodings, one-hot location code constants and small decode helpers.
package game_defs;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    ACCEPT   = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  // Column sense with no key down (pulled-up, active-low lines).
  localparam logic [2:0] ROW_IDLE = 3'b111;

  // kCode[5:3] column one-hot.
  localparam logic [2:0] KCODE_C0 = 3'b001;
  localparam logic [2:0] KCODE_C1 = 3'b010;
  localparam logic [2:0] KCODE_C2 = 3'b100;

  // kCode[2:0] row one-hot; row 0 is the MSB.
  localparam logic [2:0] KCODE_R0 = 3'b100;
  localparam logic [2:0] KCODE_R1 = 3'b010;
  localparam logic [2:0] KCODE_R2 = 3'b001;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned CELL_W    = 4;

  // Active-low row drive for a row index; only one line is pulled low.
  function automatic logic [2:0] row_drive(input logic [1:0] idx);
    case (idx)
      2'd1:    return 3'b101;
      2'd2:    return 3'b011;
      default: return 3'b110;
    endcase
  endfunction

  // Next row in the 0 -> 1 -> 2 -> 0 scan order.
  function automatic logic [1:0] row_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // True when exactly one column line is pulled low.
  function automatic logic one_low(input logic [2:0] c);
    return (c == 3'b110) || (c == 3'b101) || (c == 3'b011);
  endfunction

  // Column index of a single-low column pattern.
  function automatic logic [1:0] col_index(input logic [2:0] c);
    case (c)
      3'b101:  return 2'd1;
      3'b011:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Occupancy bit position: row*3 + col.
  function automatic logic [CELL_W-1:0] cell_index(input logic [1:0] r, input logic [1:0] c);
    return ({2'b00, r} * 4'd3) + {2'b00, c};
  endfunction

  // One-hot location code {col_oh, row_oh} consumed by the display.
  function automatic logic [5:0] kcode_of(input logic [1:0] r, input logic [1:0] c);
    logic [2:0] col_oh;
    logic [2:0] row_oh;
    case (c)
      2'd1:    col_oh = KCODE_C1;
      2'd2:    col_oh = KCODE_C2;
      default: col_oh = KCODE_C0;
    endcase
    case (r)
      2'd1:    row_oh = KCODE_R1;
      2'd2:    row_oh = KCODE_R2;
      default: row_oh = KCODE_R0;
    endcase
    return {col_oh, row_oh};
  endfunction

endpackage

// File: rtl/scan_divider.sv
// Free-running scan tick generator: one-clock tick every SCAN_DIV clocks.
module scan_divider #(
  parameter int unsigned SCAN_DIV = 500000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] r_cnt;

  assign tick = (r_cnt == CntLast);

  // Count 0..SCAN_DIV-1 and wrap on the tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 3x3 keypad scanner with debounce, occupancy/turn bookkeeping and one-hot cell code output.
module keypad_scanner
  import game_defs::*;
#(
  parameter int unsigned SCAN_DIV     = 500000,
  parameter int unsigned DEBOUNCE_CNT = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           col,
  input  logic                 new_game,
  input  logic                 game_over,
  output logic [2:0]           row,
  output logic [5:0]           kCode,
  output logic                 key_valid,
  output logic                 rejected,
  output logic                 turn,
  output logic [NUM_CELLS-1:0] occupied
);

  // Extra headroom so the increment past DEBOUNCE_CNT never wraps.
  localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 2);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CNT);

  logic                 w_tick;
  logic [2:0]           r_col_meta;
  logic [2:0]           r_col_sync;

  scan_state_e          r_state;
  scan_state_e          w_state_d;
  logic [1:0]           r_row_idx;
  logic [1:0]           w_row_idx_d;
  logic [2:0]           r_col_lat;
  logic [2:0]           w_col_lat_d;
  logic [CntW-1:0]      r_cnt;
  logic [CntW-1:0]      w_cnt_d;
  logic [CntW-1:0]      w_cnt_inc;
  logic [5:0]           r_kcode;
  logic [5:0]           w_kcode_d;
  logic                 r_key_valid;
  logic                 w_key_valid_d;
  logic                 r_rejected;
  logic                 w_rejected_d;
  logic                 r_turn;
  logic                 w_turn_d;
  logic [NUM_CELLS-1:0] r_occupied;
  logic [NUM_CELLS-1:0] w_occupied_d;
  logic [1:0]           w_col_idx;
  logic [CELL_W-1:0]    w_cell;

  scan_divider #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_divider (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  // Two-flop synchronizer for the asynchronous column sense lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col_meta <= ROW_IDLE;
      r_col_sync <= ROW_IDLE;
    end else begin
      r_col_meta <= col;
      r_col_sync <= r_col_meta;
    end
  end

  assign w_cnt_inc = r_cnt + CntW'(1);
  assign w_col_idx = col_index(r_col_lat);
  assign w_cell    = cell_index(r_row_idx, w_col_idx);

  // Scan/debounce FSM next state plus board, turn and pulse next values.
  always_comb begin
    w_state_d     = r_state;
    w_row_idx_d   = r_row_idx;
    w_col_lat_d   = r_col_lat;
    w_cnt_d       = r_cnt;
    w_kcode_d     = r_kcode;
    w_key_valid_d = 1'b0;
    w_rejected_d  = 1'b0;
    w_turn_d      = r_turn;
    w_occupied_d  = r_occupied;

    unique case (r_state)
      SCAN: begin
        if (w_tick) begin
          if (one_low(r_col_sync)) begin
            w_col_lat_d = r_col_sync;
            w_cnt_d     = CntW'(1);
            w_state_d   = DEBOUNCE;
          end else begin
            // Idle or multi-key ghosting: keep scanning.
            w_row_idx_d = row_next(r_row_idx);
          end
        end
      end
      DEBOUNCE: begin
        if (w_tick) begin
          if (r_col_sync == r_col_lat) begin
            w_cnt_d = w_cnt_inc;
            if (w_cnt_inc >= CntMax) begin
              w_state_d = ACCEPT;
            end
          end else begin
            w_cnt_d     = '0;
            w_row_idx_d = row_next(r_row_idx);
            w_state_d   = SCAN;
          end
        end
      end
      ACCEPT: begin
        if (!new_game) begin
          if (game_over || r_occupied[w_cell]) begin
            w_rejected_d = 1'b1;
          end else begin
            w_key_valid_d        = 1'b1;
            w_kcode_d            = kcode_of(r_row_idx, w_col_idx);
            w_occupied_d[w_cell] = 1'b1;
            w_turn_d             = ~r_turn;
          end
        end
        w_cnt_d   = '0;
        w_state_d = RELEASE;
      end
      RELEASE: begin
        if (w_tick) begin
          if (r_col_sync == ROW_IDLE) begin
            if (w_cnt_inc >= CntMax) begin
              w_cnt_d     = '0;
              w_row_idx_d = row_next(r_row_idx);
              w_state_d   = SCAN;
            end else begin
              w_cnt_d = w_cnt_inc;
            end
          end else begin
            w_cnt_d = '0;
          end
        end
      end
      default: begin
        w_state_d = SCAN;
      end
    endcase

    // New game clears the board in any state; the scan FSM keeps running.
    if (new_game) begin
      w_occupied_d = '0;
      w_turn_d     = 1'b0;
      w_kcode_d    = '0;
    end
  end

  // State, debounce and board registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SCAN;
      r_row_idx   <= 2'd0;
      r_col_lat   <= ROW_IDLE;
      r_cnt       <= '0;
      r_kcode     <= '0;
      r_key_valid <= 1'b0;
      r_rejected  <= 1'b0;
      r_turn      <= 1'b0;
      r_occupied  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_row_idx   <= w_row_idx_d;
      r_col_lat   <= w_col_lat_d;
      r_cnt       <= w_cnt_d;
      r_kcode     <= w_kcode_d;
      r_key_valid <= w_key_valid_d;
      r_rejected  <= w_rejected_d;
      r_turn      <= w_turn_d;
      r_occupied  <= w_occupied_d;
    end
  end

  assign row       = row_drive(r_row_idx);
  assign kCode     = r_kcode;
  assign key_valid = r_key_valid;
  assign rejected  = r_rejected;
  assign turn      = r_turn;
  assign occupied  = r_occupied;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a press table plus hand-written reset/bounce/new_game cases.
module tb_keypad_scanner;
  import game_defs::*;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DEBOUNCE_CNT = 2;
  localparam int          TICK         = SCAN_DIV;
  localparam int          NVEC         = 12;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] col;
  logic       new_game;
  logic       game_over;
  logic [2:0] row;
  logic [5:0] kCode;
  logic       key_valid;
  logic       rejected;
  logic       turn;
  logic [8:0] occupied;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .col       (col),
    .new_game  (new_game),
    .game_over (game_over),
    .row       (row),
    .kCode     (kCode),
    .key_valid (key_valid),
    .rejected  (rejected),
    .turn      (turn),
    .occupied  (occupied)
  );

  always #5 clk = ~clk;

  // Keypad model: a held key pulls its column low only while its row is driven.
  int   key_r = 0;
  int   key_c = 0;
  logic key_down = 1'b0;

  function automatic logic [2:0] row_pat(input int r);
    case (r)
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  function automatic logic [2:0] col_pat(input int c);
    case (c)
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  assign col = (key_down && (row == row_pat(key_r))) ? col_pat(key_c) : 3'b111;

  // Pulse monitor.
  int         kv_total   = 0;
  int         rej_total  = 0;
  int         both_err   = 0;
  int         consec_err = 0;
  logic       prev_pulse = 1'b0;
  logic [5:0] last_kcode = '0;

  always @(negedge clk) begin
    if (key_valid) begin
      kv_total   = kv_total + 1;
      last_kcode = kCode;
    end
    if (rejected) rej_total = rej_total + 1;
    if (key_valid && rejected) both_err = both_err + 1;
    if ((key_valid || rejected) && prev_pulse) consec_err = consec_err + 1;
    prev_pulse = key_valid || rejected;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input int r, input int c, input int hold_ticks);
    key_r    = r;
    key_c    = c;
    key_down = 1'b1;
    repeat (hold_ticks * TICK) @(negedge clk);
    key_down = 1'b0;
    repeat (8 * TICK) @(negedge clk);
  endtask

  task automatic wait_state(input scan_state_e s, output bit found);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dut.r_state == s) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Wait until the row drive moves onto pat from some other row.
  task automatic wait_row_entry(input logic [2:0] pat, output bit found);
    bit left;
    left  = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (row != pat) begin
        left = 1'b1;
      end else if (left) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int         r;
    int         c;
    int         hold;
    bit         go;
    int         exp_kv;
    int         exp_rej;
    logic [5:0] exp_kcode;
    bit         exp_turn;
    logic [8:0] exp_occ;
  } vec_t;

  vec_t vecs[NVEC];

  initial begin
    int kv0;
    int rj0;
    bit found;

    vecs[0]  = '{0, 0,  8, 1'b0, 1, 0, 6'b001100, 1'b1, 9'h001};
    vecs[1]  = '{0, 0,  8, 1'b0, 0, 1, 6'b001100, 1'b1, 9'h001};
    vecs[2]  = '{2, 2, 20, 1'b0, 1, 0, 6'b100001, 1'b0, 9'h101};
    vecs[3]  = '{1, 1,  8, 1'b1, 0, 1, 6'b100001, 1'b0, 9'h101};
    vecs[4]  = '{1, 1,  8, 1'b0, 1, 0, 6'b010010, 1'b1, 9'h111};
    vecs[5]  = '{0, 2,  8, 1'b0, 1, 0, 6'b100100, 1'b0, 9'h115};
    vecs[6]  = '{0, 1,  8, 1'b0, 1, 0, 6'b010100, 1'b1, 9'h117};
    vecs[7]  = '{1, 0,  8, 1'b0, 1, 0, 6'b001010, 1'b0, 9'h11F};
    vecs[8]  = '{1, 2,  8, 1'b0, 1, 0, 6'b100010, 1'b1, 9'h13F};
    vecs[9]  = '{2, 0,  8, 1'b0, 1, 0, 6'b001001, 1'b0, 9'h17F};
    vecs[10] = '{2, 1,  8, 1'b0, 1, 0, 6'b010001, 1'b1, 9'h1FF};
    vecs[11] = '{1, 1,  8, 1'b0, 0, 1, 6'b010001, 1'b1, 9'h1FF};

    reset_n   = 1'b0;
    new_game  = 1'b0;
    game_over = 1'b0;
    #2;
    check("reset row", row, 3'b110);
    check("reset kCode", kCode, 6'd0);
    check("reset turn", turn, 1'b0);
    check("reset occupied", occupied, 9'h000);
    check("reset key_valid", key_valid, 1'b0);
    check("reset rejected", rejected, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Bounce: r0c0 low for a single tick sample only.
    kv0 = kv_total;
    rj0 = rej_total;
    wait_row_entry(3'b110, found);
    check("bounce row0 reached", found, 1'b1);
    key_r    = 0;
    key_c    = 0;
    key_down = 1'b1;
    repeat (TICK) @(negedge clk);
    key_down = 1'b0;
    repeat (6 * TICK) @(negedge clk);
    check("bounce key_valid count", kv_total - kv0, 0);
    check("bounce rejected count", rej_total - rj0, 0);
    wait_row_entry(3'b101, found);
    check("bounce scan resumes", found, 1'b1);

    // Press table.
    for (int i = 0; i < NVEC; i++) begin
      kv0       = kv_total;
      rj0       = rej_total;
      game_over = vecs[i].go;
      press(vecs[i].r, vecs[i].c, vecs[i].hold);
      game_over = 1'b0;
      check($sformatf("v%0d key_valid count", i), kv_total - kv0, vecs[i].exp_kv);
      check($sformatf("v%0d rejected count", i), rej_total - rj0, vecs[i].exp_rej);
      check($sformatf("v%0d kCode", i), kCode, vecs[i].exp_kcode);
      check($sformatf("v%0d turn", i), turn, vecs[i].exp_turn);
      check($sformatf("v%0d occupied", i), occupied, vecs[i].exp_occ);
      if (vecs[i].exp_kv == 1)
        check($sformatf("v%0d kCode with pulse", i), last_kcode, vecs[i].exp_kcode);
    end

    // Reset while debouncing a press on a full board.
    kv0      = kv_total;
    rj0      = rej_total;
    key_r    = 1;
    key_c    = 1;
    key_down = 1'b1;
    wait_state(DEBOUNCE, found);
    check("reached DEBOUNCE", found, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("midrun reset row", row, 3'b110);
    check("midrun reset kCode", kCode, 6'd0);
    check("midrun reset turn", turn, 1'b0);
    check("midrun reset occupied", occupied, 9'h000);
    check("midrun reset key_valid", key_valid, 1'b0);
    check("midrun reset rejected", rejected, 1'b0);
    repeat (3) @(negedge clk);
    key_down = 1'b0;
    reset_n  = 1'b1;
    repeat (10 * TICK) @(negedge clk);
    check("midrun reset no key_valid", kv_total - kv0, 0);
    check("midrun reset no rejected", rej_total - rj0, 0);

    // Plain new_game pulse clears board, turn and kCode.
    press(0, 0, 8);
    check("pre new_game occupied", occupied, 9'h001);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    check("new_game occupied", occupied, 9'h000);
    check("new_game turn", turn, 1'b0);
    check("new_game kCode", kCode, 6'd0);

    // new_game in the ACCEPT clock of r1c2 overrides the accept.
    press(2, 0, 8);
    check("pre override occupied", occupied, 9'h040);
    check("pre override turn", turn, 1'b1);
    kv0      = kv_total;
    rj0      = rej_total;
    key_r    = 1;
    key_c    = 2;
    key_down = 1'b1;
    wait_state(ACCEPT, found);
    check("reached ACCEPT", found, 1'b1);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    key_down = 1'b0;
    repeat (8 * TICK) @(negedge clk);
    check("override key_valid count", kv_total - kv0, 0);
    check("override rejected count", rej_total - rj0, 0);
    check("override occupied", occupied, 9'h000);
    check("override turn", turn, 1'b0);
    check("override kCode", kCode, 6'd0);

    check("key_valid with rejected", both_err, 0);
    check("pulses in consecutive clks", consec_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
